// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - multicycle MIPS controller FSM over a shared ready-handshaked memory
module mips_multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     r_state;
    // lw/sw choice is captured in DECODE so MEMADR does not look at op again
    logic       r_is_sw;

    logic       w_funct_ok;
    logic       w_decode_ok;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_mem_req;
    logic       w_pcwrite;
    logic       w_branch;
    logic [1:0] w_aluop;

    // Legality of the instruction currently presented in the instruction register
    always_comb begin
        w_funct_ok  = (funct == 6'b100000) || (funct == 6'b100010) ||
                      (funct == 6'b100100) || (funct == 6'b100101) ||
                      (funct == 6'b101010);
        w_decode_ok = ((op == OP_RTYPE) && w_funct_ok) || (op == OP_LW) ||
                      (op == OP_SW) || (op == OP_BEQ) || (op == OP_ADDI) ||
                      (op == OP_J);
    end

    // State register and next-state sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_is_sw <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:   r_state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    r_is_sw <= (op == OP_SW);
                    if (!w_decode_ok)                    r_state <= S_FETCH;
                    else if (op == OP_LW || op == OP_SW) r_state <= S_MEMADR;
                    else if (op == OP_RTYPE)             r_state <= S_EXECUTE;
                    else if (op == OP_BEQ)               r_state <= S_BRANCH;
                    else if (op == OP_ADDI)              r_state <= S_ADDIEX;
                    else                                 r_state <= S_JUMP;
                end
                S_MEMADR:  r_state <= r_is_sw ? S_MEMWR : S_MEMRD;
                S_MEMRD:   r_state <= mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:   r_state <= S_FETCH;
                S_MEMWR:   r_state <= mem_ready ? S_FETCH : S_MEMWR;
                S_EXECUTE: r_state <= S_ALUWB;
                S_ALUWB:   r_state <= S_FETCH;
                S_BRANCH:  r_state <= S_FETCH;
                S_ADDIEX:  r_state <= S_ADDIWB;
                S_ADDIWB:  r_state <= S_FETCH;
                S_JUMP:    r_state <= S_FETCH;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of datapath selects and raw enables from the current state
    always_comb begin
        w_mem_req  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_aluop    = 2'b00;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                alusrcb   = 2'b01;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                iord      = 1'b1;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                w_mem_req  = 1'b1;
                iord       = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                w_aluop = 2'b10;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                w_aluop  = 2'b01;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:  w_regwrite = 1'b1;
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU function: fixed add/sub, or funct-decoded for R-type execute
    always_comb begin
        alucontrol = 3'b010;
        if (w_aluop == 2'b01) begin
            alucontrol = 3'b110;
        end else if (w_aluop == 2'b10) begin
            case (funct)
                6'b100010: alucontrol = 3'b110;
                6'b100100: alucontrol = 3'b000;
                6'b100101: alucontrol = 3'b001;
                6'b101010: alucontrol = 3'b111;
                default:   alucontrol = 3'b010;
            endcase
        end
    end

    // Enables are squashed while reset is held so an in-flight write stops immediately
    assign mem_req  = w_mem_req & ~reset;
    assign memwrite = w_memwrite & ~reset;
    assign irwrite  = w_irwrite & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign pcen     = (w_pcwrite | (w_branch & zero)) & ~reset;
    assign illegal  = (r_state == S_DECODE) & ~w_decode_ok & ~reset;
    assign state    = r_state;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb/tb_mips_multicycle_controller.sv - scoreboard bench for mips_multicycle_controller
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       pcen, illegal;
    logic [3:0] state;

    mips_multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    // dyn = {mem_req, memwrite, irwrite, regwrite, pcen, illegal}
    typedef struct packed {
        logic [3:0] st;
        logic [5:0] dyn;
        logic [2:0] alu;
    } exp_t;

    localparam logic [5:0] D_NONE = 6'b000000;
    localparam logic [5:0] D_FR   = 6'b101010;
    localparam logic [5:0] D_FW   = 6'b100000;
    localparam logic [5:0] D_RD   = 6'b100000;
    localparam logic [5:0] D_WR   = 6'b110000;
    localparam logic [5:0] D_WB   = 6'b000100;
    localparam logic [5:0] D_PC   = 6'b000010;
    localparam logic [5:0] D_ILL  = 6'b000001;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] JNK = 6'b111111;

    // {iord, regdst, memtoreg, alusrca, alusrcb[1:0], pcsrc[1:0]} per state
    logic [7:0] stat_tab [0:11];

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cyc   = 0;
    bit   done    = 1'b0;

    initial begin
        stat_tab[0]  = 8'b0000_0100;
        stat_tab[1]  = 8'b0000_1100;
        stat_tab[2]  = 8'b0001_1000;
        stat_tab[3]  = 8'b1000_0000;
        stat_tab[4]  = 8'b0010_0000;
        stat_tab[5]  = 8'b1000_0000;
        stat_tab[6]  = 8'b0001_0000;
        stat_tab[7]  = 8'b0100_0000;
        stat_tab[8]  = 8'b0001_0001;
        stat_tab[9]  = 8'b0001_1000;
        stat_tab[10] = 8'b0000_0000;
        stat_tab[11] = 8'b0000_0010;
    end

    task automatic check(input string name, input int cyc, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // One cycle of stimulus; expected outputs for that cycle go into the scoreboard
    task automatic cyc(input logic rst, input logic mr, input logic z, input logic [5:0] o,
                       input logic [5:0] f, input logic [3:0] st, input logic [5:0] dyn,
                       input logic [2:0] alu);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        mem_ready = mr;
        zero      = z;
        op        = o;
        funct     = f;
        e.st  = st;
        e.dyn = dyn;
        e.alu = alu;
        q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents an output set; compare against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cyc++;
                check("state", n_cyc, {12'd0, state}, {12'd0, e.st});
                check("enables", n_cyc, {10'd0, mem_req, memwrite, irwrite, regwrite, pcen, illegal},
                      {10'd0, e.dyn});
                check("alucontrol", n_cyc, {13'd0, alucontrol}, {13'd0, e.alu});
                if (e.st < 4'd12)
                    check("selects", n_cyc, {8'd0, iord, regdst, memtoreg, alusrca, alusrcb, pcsrc},
                          {8'd0, stat_tab[e.st]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [5:0] r_fn  [0:4];
    logic [2:0] r_alu [0:4];

    initial begin
        r_fn[0] = 6'b100010; r_alu[0] = 3'b110;
        r_fn[1] = 6'b101010; r_alu[1] = 3'b111;
        r_fn[2] = 6'b100000; r_alu[2] = 3'b010;
        r_fn[3] = 6'b100100; r_alu[3] = 3'b000;
        r_fn[4] = 6'b100101; r_alu[4] = 3'b001;

        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; op = JNK; funct = JNK;

        // reset held 3 cycles with mem_ready=1: everything quiet in FETCH
        repeat (3) cyc(1, 1, 0, JNK, JNK, 4'd0, D_NONE, 3'b010);

        // addi right after release: first cycle fetches with irwrite/pcen
        cyc(0, 1, 0, JNK,  JNK, 4'd0,  D_FR,   3'b010);
        cyc(0, 1, 0, ADDI, JNK, 4'd1,  D_NONE, 3'b010);
        cyc(0, 1, 0, ADDI, JNK, 4'd9,  D_NONE, 3'b010);
        cyc(0, 1, 0, ADDI, JNK, 4'd10, D_WB,   3'b010);

        // lw: two wait cycles in FETCH, one in MEMRD
        cyc(0, 0, 0, JNK, JNK, 4'd0, D_FW,   3'b010);
        cyc(0, 0, 0, JNK, JNK, 4'd0, D_FW,   3'b010);
        cyc(0, 1, 0, JNK, JNK, 4'd0, D_FR,   3'b010);
        cyc(0, 1, 0, LW,  JNK, 4'd1, D_NONE, 3'b010);
        cyc(0, 1, 0, LW,  JNK, 4'd2, D_NONE, 3'b010);
        cyc(0, 0, 0, LW,  JNK, 4'd3, D_RD,   3'b010);
        cyc(0, 1, 0, LW,  JNK, 4'd3, D_RD,   3'b010);
        cyc(0, 1, 0, LW,  JNK, 4'd4, D_WB,   3'b010);

        // R-type sequence; mem_ready low outside FETCH must not stall
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, JNK, JNK,     4'd0, D_FR,   3'b010);
            cyc(0, 0, 0, RT,  r_fn[i], 4'd1, D_NONE, 3'b010);
            cyc(0, 0, 0, RT,  r_fn[i], 4'd6, D_NONE, r_alu[i]);
            cyc(0, 0, 0, RT,  r_fn[i], 4'd7, D_WB,   3'b010);
        end

        // beq taken (zero=1 in DECODE must not raise pcen), then not taken
        cyc(0, 1, 1, JNK, JNK, 4'd0, D_FR,   3'b010);
        cyc(0, 1, 1, BEQ, JNK, 4'd1, D_NONE, 3'b010);
        cyc(0, 1, 1, BEQ, JNK, 4'd8, D_PC,   3'b110);
        cyc(0, 1, 0, JNK, JNK, 4'd0, D_FR,   3'b010);
        cyc(0, 1, 0, BEQ, JNK, 4'd1, D_NONE, 3'b010);
        cyc(0, 1, 0, BEQ, JNK, 4'd8, D_NONE, 3'b110);

        // j
        cyc(0, 1, 0, JNK, JNK, 4'd0,  D_FR,   3'b010);
        cyc(0, 1, 0, JMP, JNK, 4'd1,  D_NONE, 3'b010);
        cyc(0, 1, 0, JMP, JNK, 4'd11, D_PC,   3'b010);

        // illegal opcode, then R-type with unsupported funct
        cyc(0, 1, 0, JNK, JNK,     4'd0, D_FR,  3'b010);
        cyc(0, 1, 0, JNK, JNK,     4'd1, D_ILL, 3'b010);
        cyc(0, 1, 0, RT,  6'b0,    4'd0, D_FR,  3'b010);
        cyc(0, 1, 0, RT,  6'b0,    4'd1, D_ILL, 3'b010);

        // sw completing normally; op changes in MEMADR are ignored
        cyc(0, 1, 0, JNK, JNK, 4'd0, D_FR,   3'b010);
        cyc(0, 1, 0, SW,  JNK, 4'd1, D_NONE, 3'b010);
        cyc(0, 1, 0, LW,  JNK, 4'd2, D_NONE, 3'b010);
        cyc(0, 0, 0, LW,  JNK, 4'd5, D_WR,   3'b010);
        cyc(0, 1, 0, LW,  JNK, 4'd5, D_WR,   3'b010);

        // sw aborted by reset mid-handshake
        cyc(0, 1, 0, JNK, JNK, 4'd0, D_FR,   3'b010);
        cyc(0, 1, 0, SW,  JNK, 4'd1, D_NONE, 3'b010);
        cyc(0, 1, 0, SW,  JNK, 4'd2, D_NONE, 3'b010);
        cyc(0, 0, 0, SW,  JNK, 4'd5, D_WR,   3'b010);
        cyc(1, 0, 0, SW,  JNK, 4'd5, D_NONE, 3'b010);
        cyc(0, 0, 0, JNK, JNK, 4'd0, D_FW,   3'b010);
        cyc(0, 0, 0, JNK, JNK, 4'd0, D_FW,   3'b010);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual=%0d left required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Finite-state controller that sequences a multicycle MIPS datapath over a single shared instruction/data memory with a ready handshake. It replaces the single-cycle combinational controller when the core moves to a multicycle organisation. Each instruction is broken into FETCH, DECODE and per-class execute and writeback states, and the block drives every datapath select and enable from the current state.

## Interface
- No parameters. State encoding and opcode/funct values are fixed as listed below.
- clk  in  1  system clock; all state changes occur on the rising edge.
- reset  in  1  synchronous, active-high; returns the FSM to FETCH.
- op  in  6  instruction register bits [31:26]; stable from DECODE onward.
- funct  in  6  instruction register bits [5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access in this cycle.
- mem_req  out  1  memory access in progress (FETCH, MEMRD, MEMWR).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- regdst  out  1  register destination select: 0 = rt, 1 = rd.
- memtoreg  out  1  writeback data select: 0 = ALUOut, 1 = Data register.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- alucontrol  out  3  ALU function select.
- pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- pcen  out  1  PC write enable, equal to pcwrite | (branch & zero).
- illegal  out  1  one-cycle pulse when an unsupported instruction is decoded.
- state  out  4  current state, for debug and verification.

## Operation
- States and encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5.
  - EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11.
  - Codes 12–15 go to FETCH on the next edge and drive all enables 0.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Supported R-type funct values and alucontrol:
  - add 100000 -> 010, sub 100010 -> 110, and 100100 -> 000.
  - or 100101 -> 001, slt 101010 -> 111.
- Internal aluop drives alucontrol as follows: 00 -> 010 (add), 01 -> 110 (sub), 10 -> decoded from funct.
- Outputs are Moore functions of state, except three cases:
  - irwrite and pcwrite are gated by mem_ready.
  - memwrite is held for the whole MEMWR state.
  - pcen uses zero.
- Any output not listed for a state is 0.
- Per-state outputs and next state:
  - FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=mem_ready, pcwrite=mem_ready. Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
  - DECODE: alusrca=0, alusrcb=11, aluop=00 (precomputes the branch target). Next state:
    - lw or sw -> MEMADR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - addi -> ADDIEX
    - j -> JUMP
    - unsupported opcode, or R-type with unsupported funct -> FETCH, with illegal=1 for this cycle.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_req=1, iord=1. Holds until mem_ready, then goes to MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Goes to FETCH.
  - MEMWR: mem_req=1, iord=1, memwrite=1. Holds until mem_ready, then goes to FETCH.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10. Goes to ALUWB.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1. Goes to FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Goes to FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00. Goes to ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1. Goes to FETCH.
  - JUMP: pcsrc=10, pcwrite=1. Goes to FETCH.

## Timing
- Reset:
  - While reset=1, memwrite, irwrite, regwrite, pcen, mem_req and illegal are forced to 0.
  - The edge that samples reset=1 loads FETCH (state=0), regardless of any access in progress, including MEMWR mid-handshake.
  - The first fetch begins in the cycle after reset deasserts.
- Cycles per instruction with mem_ready held at 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Illegal instruction: 2 (FETCH, DECODE).
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. No other state samples mem_ready.
- pcen is combinational from zero in BRANCH; PC updates on the edge that leaves BRANCH.
- op and funct are sampled only in DECODE and EXECUTE; changes in other states have no effect.

## Test plan
- Reset: hold reset for 3 cycles with mem_ready=1, then release -> state=0 and all enables 0 during reset. The cycle after release shows irwrite=1, pcen=1.
- lw with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMRD:
  - State sequence 0,0,0,1,2,3,3,4,0.
  - regwrite=1 with memtoreg=1 only in state 4.
- R-type sub (funct 100010), then slt (funct 101010) -> alucontrol=110, then 111, in EXECUTE; ALUWB shows regdst=1, regwrite=1.
- beq:
  - With zero=1 in BRANCH -> pcen=1, pcsrc=01.
  - With zero=0 -> pcen=0; the FSM returns to FETCH after 3 cycles in both cases.
- sw, with reset asserted while in MEMWR with mem_ready=0 -> memwrite drops to 0 immediately; state=0 after the edge.
- op=111111 -> illegal=1 for exactly the DECODE cycle, then FETCH. R-type with funct=000000 behaves the same.
